// File: rtl/cl_axil_pkg.sv
// Shared definitions for the AXI-Lite register file.
//   RESP_OKAY / RESP_SLVERR : AXI response codes
//   WINDOW_W                : address bits decoded inside one 4 KB window
//   wr_state_e / rd_state_e : write and read channel FSM states
//   merge_bytes()           : byte-enable merge of a write into a stored word
package cl_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int WINDOW_W = 12;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] result;
        for (int b = 0; b < 4; b++) begin
            result[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/axil_bus_t.sv
// AXI-Lite bus bundle, one lane of each signal per slot.
//   slave modport  : address/data/handshake inputs, ready/response outputs
//   master modport : the mirror image
interface axil_bus_t #(
    parameter int NUM_SLOTS = 1
);
    logic [NUM_SLOTS*32-1:0] awaddr;
    logic [NUM_SLOTS-1:0]    awvalid;
    logic [NUM_SLOTS-1:0]    awready;
    logic [NUM_SLOTS*32-1:0] wdata;
    logic [NUM_SLOTS*4-1:0]  wstrb;
    logic [NUM_SLOTS-1:0]    wvalid;
    logic [NUM_SLOTS-1:0]    wready;
    logic [NUM_SLOTS*2-1:0]  bresp;
    logic [NUM_SLOTS-1:0]    bvalid;
    logic [NUM_SLOTS-1:0]    bready;
    logic [NUM_SLOTS*32-1:0] araddr;
    logic [NUM_SLOTS-1:0]    arvalid;
    logic [NUM_SLOTS-1:0]    arready;
    logic [NUM_SLOTS*32-1:0] rdata;
    logic [NUM_SLOTS*2-1:0]  rresp;
    logic [NUM_SLOTS-1:0]    rvalid;
    logic [NUM_SLOTS-1:0]    rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/cl_axil_regfile.sv
// AXI-Lite slave register file.
//   aclk, areset : clock and asynchronous active-high reset
//   axil_s_bus   : AXI-Lite slave port (single slot)
//   regs_o       : all words, word i at [32i+31:32i]; word 0 = ID_VALUE,
//                  word NUM_REGS-1 = status_i, the rest read/write
//   status_i     : live status word, read-only at word NUM_REGS-1
//   wr_pulse_o   : one-cycle strobe on the word updated by a write
module cl_axil_regfile #(
    parameter logic [31:0] ID_VALUE = 32'h0000_0000,
    parameter int          NUM_REGS = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    axil_bus_t.slave              axil_s_bus,
    output logic [NUM_REGS*32-1:0] regs_o,
    input  logic [31:0]           status_i,
    output logic [NUM_REGS-1:0]   wr_pulse_o
);
    import cl_axil_pkg::*;

    localparam int IDX_W = $clog2(NUM_REGS);
    typedef logic [IDX_W-1:0] idx_t;

    // ---------------- address decode ----------------
    logic [31:0] awaddr, araddr;
    idx_t        aw_idx, ar_idx;
    logic        aw_oor, ar_oor;
    logic        unused_addr_bits;

    assign awaddr = axil_s_bus.awaddr[31:0];
    assign araddr = axil_s_bus.araddr[31:0];
    assign aw_idx = awaddr[IDX_W+1:2];
    assign ar_idx = araddr[IDX_W+1:2];
    assign aw_oor = |awaddr[WINDOW_W-1:IDX_W+2];
    assign ar_oor = |araddr[WINDOW_W-1:IDX_W+2];
    // Byte offset and bits above the 4 KB window are deliberately ignored.
    assign unused_addr_bits = ^{awaddr[31:WINDOW_W], awaddr[1:0],
                                araddr[31:WINDOW_W], araddr[1:0]};

    // ---------------- state ----------------
    wr_state_e             w_state_q, w_state_d;
    rd_state_e             r_state_q, r_state_d;
    logic                  rdy_en_q;       // holds all readies low until the first edge after reset
    logic                  aw_held_q, w_held_q, aw_oor_q;
    idx_t                  aw_idx_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic [1:0]            bresp_q, rresp_q;
    logic [31:0]           rdata_q;
    logic [NUM_REGS-1:0]   wr_pulse_q;
    logic [31:0]           regs_q [1:NUM_REGS-2];
    logic [31:0]           word_val [NUM_REGS];

    logic awready, wready, bvalid, arready, rvalid;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, commit, wr_writable, wr_oor;
    idx_t        wr_idx;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;

    assign aw_hs = axil_s_bus.awvalid[0] & awready;
    assign w_hs  = axil_s_bus.wvalid[0]  & wready;
    assign b_hs  = bvalid & axil_s_bus.bready[0];
    assign ar_hs = axil_s_bus.arvalid[0] & arready;
    assign r_hs  = rvalid & axil_s_bus.rready[0];

    // A beat accepted this cycle is used directly so AW+W in one cycle commits at once.
    assign wr_idx  = aw_held_q ? aw_idx_q : aw_idx;
    assign wr_oor  = aw_held_q ? aw_oor_q : aw_oor;
    assign wr_data = w_held_q  ? wdata_q  : axil_s_bus.wdata[31:0];
    assign wr_strb = w_held_q  ? wstrb_q  : axil_s_bus.wstrb[3:0];
    assign commit  = (w_state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign wr_writable = !wr_oor && (wr_idx != idx_t'(0)) && (wr_idx != idx_t'(NUM_REGS-1));

    // ---------------- write FSM ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            rdy_en_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            rdy_en_q  <= 1'b1;
        end
    end

    // NOTE: defaulting every output first keeps combinational blocks latch-free.
    always_comb begin
        w_state_d = w_state_q;
        unique case (w_state_q)
            W_IDLE: if (commit) w_state_d = W_RESP;
            W_RESP: if (b_hs)   w_state_d = W_IDLE;
            default:            w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        awready = rdy_en_q && (w_state_q == W_IDLE) && !aw_held_q;
        wready  = rdy_en_q && (w_state_q == W_IDLE) && !w_held_q;
        bvalid  = (w_state_q == W_RESP);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_idx_q   <= '0;
            aw_oor_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
        end else begin
            if (b_hs) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_held_q <= 1'b1;
                    aw_idx_q  <= aw_idx;
                    aw_oor_q  <= aw_oor;
                end
                if (w_hs) begin
                    w_held_q <= 1'b1;
                    wdata_q  <= axil_s_bus.wdata[31:0];
                    wstrb_q  <= axil_s_bus.wstrb[3:0];
                end
            end
            if (commit) bresp_q <= wr_oor ? RESP_SLVERR : RESP_OKAY;
            // Registered so the strobe coincides with the new value on regs_o.
            wr_pulse_q <= (commit && wr_writable) ? (NUM_REGS'(1) << wr_idx) : '0;
        end
    end

    // NOTE: the register array is reset explicitly because software expects
    // every read/write word to read back as zero after reset.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 1; i < NUM_REGS-1; i++) regs_q[i] <= '0;
        end else if (commit && wr_writable) begin
            for (int i = 1; i < NUM_REGS-1; i++) begin
                if (wr_idx == idx_t'(i)) regs_q[i] <= merge_bytes(regs_q[i], wr_data, wr_strb);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) word_val[i] = '0;
        word_val[0] = ID_VALUE;
        for (int i = 1; i < NUM_REGS-1; i++) word_val[i] = regs_q[i];
        word_val[NUM_REGS-1] = status_i;
        regs_o = '0;
        for (int i = 0; i < NUM_REGS; i++) regs_o[32*i +: 32] = word_val[i];
    end

    // ---------------- read FSM ----------------
    always_comb begin
        r_state_d = r_state_q;
        unique case (r_state_q)
            R_IDLE: if (ar_hs) r_state_d = R_DATA;
            R_DATA: if (r_hs)  r_state_d = R_IDLE;
            default:           r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        arready = rdy_en_q && (r_state_q == R_IDLE);
        rvalid  = (r_state_q == R_DATA);
    end

    // Data is captured at the AR handshake, so it reflects pre-commit contents
    // and the status value of that cycle.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_hs) begin
            rdata_q <= ar_oor ? 32'h0 : word_val[ar_idx];
            rresp_q <= ar_oor ? RESP_SLVERR : RESP_OKAY;
        end
    end

    // ---------------- outputs ----------------
    assign axil_s_bus.awready = awready;
    assign axil_s_bus.wready  = wready;
    assign axil_s_bus.bvalid  = bvalid;
    assign axil_s_bus.bresp   = bresp_q;
    assign axil_s_bus.arready = arready;
    assign axil_s_bus.rvalid  = rvalid;
    assign axil_s_bus.rdata   = rdata_q;
    assign axil_s_bus.rresp   = rresp_q;
    assign wr_pulse_o         = wr_pulse_q;

endmodule

// File: tb/tb_cl_axil_regfile.sv
// Directed self-checking bench for cl_axil_regfile.
module tb_cl_axil_regfile;
    localparam logic [31:0] ID = 32'h5A5A_0001;
    localparam int          NR = 16;

    logic aclk = 1'b0;
    logic areset;
    logic [NR*32-1:0] regs;
    logic [31:0]      status;
    logic [NR-1:0]    wr_pulse;

    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic awvalid, awready, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rvalid, rready;

    int n_cmp = 0;
    int n_err = 0;
    logic [NR-1:0] pulse_at_b, pulse_after_b;

    axil_bus_t #(.NUM_SLOTS(1)) bus ();

    assign bus.awaddr  = awaddr;
    assign bus.awvalid = awvalid;
    assign bus.wdata   = wdata;
    assign bus.wstrb   = wstrb;
    assign bus.wvalid  = wvalid;
    assign bus.bready  = bready;
    assign bus.araddr  = araddr;
    assign bus.arvalid = arvalid;
    assign bus.rready  = rready;
    assign awready = bus.awready;
    assign wready  = bus.wready;
    assign bvalid  = bus.bvalid;
    assign bresp   = bus.bresp;
    assign arready = bus.arready;
    assign rvalid  = bus.rvalid;
    assign rdata   = bus.rdata;
    assign rresp   = bus.rresp;

    cl_axil_regfile #(.ID_VALUE(ID), .NUM_REGS(NR)) dut (
        .aclk       (aclk),
        .areset     (areset),
        .axil_s_bus (bus),
        .regs_o     (regs),
        .status_i   (status),
        .wr_pulse_o (wr_pulse)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] word(input int i);
        return regs[32*i +: 32];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic axil_write(input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, output logic [1:0] resp);
        logic aw_f, w_f, done;
        @(negedge aclk);
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
        done = 1'b0; resp = 2'b11; pulse_at_b = '1;
        for (int n = 0; n < 20 && !done; n++) begin
            aw_f = awvalid && awready;
            w_f  = wvalid && wready;
            @(posedge aclk); #1;
            if (aw_f) awvalid = 1'b0;
            if (w_f)  wvalid  = 1'b0;
            @(negedge aclk);
            if (bvalid) begin
                done = 1'b1; resp = bresp; pulse_at_b = wr_pulse;
            end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check("wr_bvalid_seen", 32'(done), 32'd1);
        @(negedge aclk);
        pulse_after_b = wr_pulse;
    endtask

    task automatic axil_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        logic ar_f, done;
        @(negedge aclk);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        done = 1'b0; d = 32'hxxxx_xxxx; resp = 2'b11;
        for (int n = 0; n < 20 && !done; n++) begin
            ar_f = arvalid && arready;
            @(posedge aclk); #1;
            if (ar_f) arvalid = 1'b0;
            @(negedge aclk);
            if (rvalid) begin
                done = 1'b1; d = rdata; resp = rresp;
            end
        end
        arvalid = 1'b0;
        check("rd_rvalid_seen", 32'(done), 32'd1);
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] d;
        logic        stable;

        areset = 1'b1; status = 32'h0000_0000;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0;

        // Reset state
        repeat (3) @(negedge aclk);
        check("rst_awready", 32'(awready), 0);
        check("rst_wready",  32'(wready),  0);
        check("rst_arready", 32'(arready), 0);
        check("rst_bvalid",  32'(bvalid),  0);
        check("rst_rvalid",  32'(rvalid),  0);
        check("rst_rdata",   rdata, 0);
        check("rst_word1",   word(1), 0);
        check("rst_pulse",   32'(wr_pulse), 0);
        areset = 1'b0;
        #1 check("rst_rel_awready_before_edge", 32'(awready), 0);
        @(negedge aclk);
        check("rst_rel_awready", 32'(awready), 1);
        check("rst_rel_wready",  32'(wready),  1);
        check("rst_rel_arready", 32'(arready), 1);

        // Basic write/read of word 1
        axil_write(32'h0000_0004, 32'hDEAD_BEEF, 4'hF, resp);
        check("w1_bresp", 32'(resp), 32'h0);
        check("w1_pulse", 32'(pulse_at_b), 32'h0002);
        check("w1_pulse_gone", 32'(pulse_after_b), 32'h0);
        check("w1_word", word(1), 32'hDEAD_BEEF);
        axil_read(32'h0000_0004, d, resp);
        check("r1_rdata", d, 32'hDEAD_BEEF);
        check("r1_rresp", 32'(resp), 32'h0);

        // W three cycles ahead of AW, word 2
        @(negedge aclk);
        wdata = 32'h0000_0222; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
        check("wfirst_wready", 32'(wready), 1);
        @(posedge aclk); #1 wvalid = 1'b0;
        @(negedge aclk);
        check("wfirst_wready_held", 32'(wready), 0);
        check("wfirst_awready", 32'(awready), 1);
        repeat (2) @(negedge aclk);
        check("wfirst_no_b", 32'(bvalid), 0);
        awaddr = 32'h0000_0008; awvalid = 1'b1;
        check("wfirst_aw_ready", 32'(awready), 1);
        @(posedge aclk); #1 awvalid = 1'b0;
        check("wfirst_bvalid", 32'(bvalid), 1);
        check("wfirst_bresp", 32'(bresp), 0);
        check("wfirst_word2", word(2), 32'h0000_0222);
        @(negedge aclk);
        @(negedge aclk);
        check("wfirst_b_done", 32'(bvalid), 0);

        // Partial strobes
        axil_write(32'h0000_000C, 32'h1122_3344, 4'hF, resp);
        axil_write(32'h0000_000C, 32'h0BCD_EF00, 4'b0101, resp);
        check("strb_resp", 32'(resp), 0);
        check("strb_word3", word(3), 32'h11CD_3300);
        axil_write(32'h0000_0014, 32'h1234_5678, 4'hF, resp);
        axil_write(32'h0000_0014, 32'hFFFF_FFFF, 4'h0, resp);
        check("strb0_resp", 32'(resp), 0);
        check("strb0_word5", word(5), 32'h1234_5678);

        // ID word and out of range
        axil_read(32'h0000_0000, d, resp);
        check("id_rdata", d, ID);
        check("id_rresp", 32'(resp), 0);
        axil_write(32'h0000_0000, 32'h0000_0000, 4'hF, resp);
        check("id_wr_resp", 32'(resp), 0);
        check("id_word0", word(0), ID);
        axil_read(32'h0000_0000, d, resp);
        check("id_rdata_after_wr", d, ID);
        axil_read(32'h0000_0800, d, resp);
        check("oor_rdata", d, 0);
        check("oor_rresp", 32'(resp), 32'h2);
        axil_write(32'h0000_0044, 32'h0000_0099, 4'hF, resp);
        check("oor_bresp", 32'(resp), 32'h2);
        check("oor_pulse", 32'(pulse_at_b), 0);
        check("oor_word1_kept", word(1), 32'hDEAD_BEEF);

        // Upper and byte-offset address bits ignored
        axil_write(32'hFFFF_F01C, 32'h7777_7777, 4'hF, resp);
        check("hi_bresp", 32'(resp), 0);
        check("hi_word7", word(7), 32'h7777_7777);
        axil_read(32'h0000_001F, d, resp);
        check("lo_rdata", d, 32'h7777_7777);

        // bready held low
        @(negedge aclk);
        awaddr = 32'h0000_0010; wdata = 32'h4444_4444; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(posedge aclk); #1 begin awvalid = 1'b0; wvalid = 1'b0; end
        stable = 1'b1;
        repeat (10) begin
            @(negedge aclk);
            if (!(bvalid && bresp == 2'b00 && !awready && !wready)) stable = 1'b0;
        end
        check("bstall_stable", 32'(stable), 1);
        bready = 1'b1;
        @(posedge aclk); #1 check("bstall_release", 32'(bvalid), 0);
        check("bstall_word4", word(4), 32'h4444_4444);

        // rready held low; status sampled at AR
        status = 32'hCAFE_F00D;
        @(negedge aclk);
        check("status_word15", word(15), 32'hCAFE_F00D);
        araddr = 32'h0000_003C; arvalid = 1'b1; rready = 1'b0;
        @(posedge aclk); #1 begin arvalid = 1'b0; status = 32'h0000_0000; end
        stable = 1'b1;
        repeat (10) begin
            @(negedge aclk);
            if (!(rvalid && rdata == 32'hCAFE_F00D && rresp == 2'b00 && !arready)) stable = 1'b0;
        end
        check("rstall_stable", 32'(stable), 1);
        rready = 1'b1;
        @(posedge aclk); #1 check("rstall_release", 32'(rvalid), 0);
        axil_read(32'h0000_003C, d, resp);
        check("status_new", d, 0);

        // Read accepted in the commit cycle of a write to the same word
        axil_write(32'h0000_0018, 32'hAAAA_0000, 4'hF, resp);
        @(negedge aclk);
        awaddr = 32'h0000_0018; wdata = 32'h5555_5555; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        araddr = 32'h0000_0018; arvalid = 1'b1; rready = 1'b1;
        @(posedge aclk); #1 begin awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; end
        check("rw_bvalid", 32'(bvalid), 1);
        check("rw_rvalid", 32'(rvalid), 1);
        check("rw_rdata_old", rdata, 32'hAAAA_0000);
        check("rw_word6_new", word(6), 32'h5555_5555);
        @(negedge aclk);

        // Reset in the middle of a write (AW only)
        @(negedge aclk);
        awaddr = 32'h0000_0020; awvalid = 1'b1; bready = 1'b1;
        @(posedge aclk); #1 awvalid = 1'b0;
        @(negedge aclk);
        areset = 1'b1;
        #1;
        check("mid_rst_awready", 32'(awready), 0);
        check("mid_rst_arready", 32'(arready), 0);
        check("mid_rst_bvalid",  32'(bvalid),  0);
        check("mid_rst_word1",   word(1), 0);
        check("mid_rst_rdata",   rdata, 0);
        @(negedge aclk);
        areset = 1'b0;
        stable = 1'b1;
        repeat (3) begin
            @(negedge aclk);
            if (bvalid) stable = 1'b0;
        end
        check("mid_rst_no_b", 32'(stable), 1);
        axil_write(32'h0000_0020, 32'h1212_1212, 4'hF, resp);
        check("post_rst_bresp", 32'(resp), 0);
        check("post_rst_pulse", 32'(pulse_at_b), 32'h0100);
        check("post_rst_word8", word(8), 32'h1212_1212);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
